// File: rtl/multitap_delay_pkg.sv
// Shared types, constants and the saturation helper for the multitap delay effect.
package multitap_delay_pkg;

  localparam int unsigned Q_FRAC = 14;
  localparam int unsigned GAIN_W = 16;

  typedef enum logic [1:0] {
    MODE_NORMAL   = 2'b00,
    MODE_PINGPONG = 2'b01,
    MODE_BYPASS   = 2'b10
  } mode_t;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Clamp a wide signed value into the signed range of a width-bit sample.
  function automatic logic signed [63:0] sat_data(input logic signed [63:0] value,
                                                   input int unsigned     width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Single-port synchronous RAM, read-first, one-cycle read latency, no reset.
module delay_ram #(
  parameter int unsigned DATA_BIT  = 16,
  parameter int unsigned DEPTH     = 32768,
  parameter int unsigned ADDR_BITS = 15
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BIT-1:0]  wdata,
  output logic [DATA_BIT-1:0]  rdata
);

  logic [DATA_BIT-1:0] mem [DEPTH];

  // Registered read of the addressed word alongside an optional write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/multitap_delay_fx.sv
// Multi-channel feedback delay with normal, ping-pong and bypass modes.
// One frame per input strobe: read all delayed taps, then write feedback
// samples and compute outputs channel by channel, then publish the frame.
module multitap_delay_fx
  import multitap_delay_pkg::*;
#(
  parameter int DATA_BIT   = 16,
  parameter int ADDR_WIDTH = 14,
  parameter int CHANNELS   = 2
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic [CHANNELS*DATA_BIT-1:0] i_audio,
  input  logic                         i_audio_valid,
  input  logic [ADDR_WIDTH-1:0]        i_delay,
  input  logic [15:0]                  i_feedback,
  input  logic [15:0]                  i_wet,
  input  logic [15:0]                  i_dry,
  input  logic [1:0]                   i_mode,
  output logic [CHANNELS*DATA_BIT-1:0] o_audio,
  output logic                         o_audio_valid,
  output logic                         o_ready,
  output logic                         o_overrun
);

  localparam int unsigned RAM_DEPTH = CHANNELS << ADDR_WIDTH;
  localparam int unsigned RAM_AW    = $clog2(RAM_DEPTH);
  localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_t                      state;
  logic [RAM_AW-1:0]           cnt;
  logic [ADDR_WIDTH-1:0]       wr_ptr;
  logic [ADDR_WIDTH-1:0]       delay_q;
  logic signed [GAIN_W-1:0]    fb_q;
  logic signed [GAIN_W-1:0]    wet_q;
  logic signed [GAIN_W-1:0]    dry_q;
  mode_t                       mode_q;
  logic signed [DATA_BIT-1:0]  x_q [CHANNELS];
  logic signed [DATA_BIT-1:0]  d_q [CHANNELS];
  logic signed [DATA_BIT-1:0]  y_q [CHANNELS];
  logic                        rd_pend;
  logic [CH_W-1:0]             rd_ch;

  logic [CH_W-1:0]             ch;
  logic [CH_W-1:0]             ch_nxt;
  logic [ADDR_WIDTH-1:0]       rd_ptr;
  logic [RAM_AW-1:0]           ch_base;
  logic                        ram_we;
  logic [RAM_AW-1:0]           ram_addr;
  logic [DATA_BIT-1:0]         ram_wdata;
  logic [DATA_BIT-1:0]         ram_rdata;

  logic signed [DATA_BIT-1:0]  x_c;
  logic signed [DATA_BIT-1:0]  d_c;
  logic signed [DATA_BIT-1:0]  f_c;
  logic signed [63:0]          wr_sum;
  logic signed [63:0]          mix_sum;
  logic signed [DATA_BIT-1:0]  wr_val;
  logic signed [DATA_BIT-1:0]  y_val;

  assign ch      = cnt[CH_W-1:0];
  assign ch_nxt  = (ch == CH_W'(CHANNELS - 1)) ? '0 : ch + 1'b1;
  assign rd_ptr  = wr_ptr - delay_q;
  assign ch_base = cnt << ADDR_WIDTH;

  // Per-channel arithmetic for the channel currently being written.
  always_comb begin
    x_c     = x_q[ch];
    d_c     = d_q[ch];
    f_c     = (mode_q == MODE_PINGPONG) ? d_q[ch_nxt] : d_c;
    wr_sum  = 64'(x_c) + ((64'(f_c) * 64'(fb_q)) >>> Q_FRAC);
    mix_sum = (64'(x_c) * 64'(dry_q) + 64'(d_c) * 64'(wet_q)) >>> Q_FRAC;
    wr_val  = DATA_BIT'(sat_data(wr_sum, DATA_BIT));
    y_val   = (mode_q == MODE_BYPASS) ? x_c : DATA_BIT'(sat_data(mix_sum, DATA_BIT));
  end

  // RAM port steering: clear sweep, tap reads, feedback writes.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      ST_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = cnt;
      end
      ST_READ: begin
        ram_addr = ch_base | RAM_AW'(rd_ptr);
      end
      ST_WRITE: begin
        ram_we    = 1'b1;
        ram_addr  = ch_base | RAM_AW'(wr_ptr);
        ram_wdata = wr_val;
      end
      default: ;
    endcase
  end

  delay_ram #(
    .DATA_BIT  (DATA_BIT),
    .DEPTH     (RAM_DEPTH),
    .ADDR_BITS (RAM_AW)
  ) u_ram (
    .clk   (i_clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Frame sequencer with registered outputs.
  // Read data lags its address by one cycle, so captures are driven by a
  // delayed read-pending flag rather than by the current state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= ST_CLEAR;
      cnt           <= '0;
      wr_ptr        <= '0;
      delay_q       <= '0;
      fb_q          <= '0;
      wet_q         <= '0;
      dry_q         <= '0;
      mode_q        <= MODE_NORMAL;
      rd_pend       <= 1'b0;
      rd_ch         <= '0;
      o_audio       <= '0;
      o_audio_valid <= 1'b0;
      o_ready       <= 1'b0;
      o_overrun     <= 1'b0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        x_q[c] <= '0;
        d_q[c] <= '0;
        y_q[c] <= '0;
      end
    end else begin
      o_audio_valid <= 1'b0;
      o_overrun     <= i_audio_valid && !o_ready;
      rd_pend       <= (state == ST_READ);
      rd_ch         <= ch;
      if (rd_pend) begin
        d_q[rd_ch] <= $signed(ram_rdata);
      end
      case (state)
        ST_CLEAR: begin
          if (cnt == RAM_AW'(RAM_DEPTH - 1)) begin
            cnt     <= '0;
            state   <= ST_IDLE;
            o_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (i_audio_valid) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
              x_q[c] <= $signed(i_audio[c*DATA_BIT +: DATA_BIT]);
            end
            delay_q <= i_delay;
            fb_q    <= $signed(i_feedback);
            wet_q   <= $signed(i_wet);
            dry_q   <= $signed(i_dry);
            mode_q  <= (i_mode == 2'b11) ? MODE_NORMAL : mode_t'(i_mode);
            o_ready <= 1'b0;
            cnt     <= '0;
            state   <= ST_READ;
          end
        end
        ST_READ: begin
          if (cnt == RAM_AW'(CHANNELS - 1)) begin
            cnt   <= '0;
            state <= ST_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          y_q[ch] <= y_val;
          if (cnt == RAM_AW'(CHANNELS - 1)) begin
            cnt   <= '0;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          for (int unsigned c = 0; c < CHANNELS; c++) begin
            o_audio[c*DATA_BIT +: DATA_BIT] <= y_q[c];
          end
          wr_ptr        <= wr_ptr + 1'b1;
          o_audio_valid <= 1'b1;
          o_ready       <= 1'b1;
          state         <= ST_IDLE;
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: doc/multitap_delay_fx.md
Name: multitap_delay_fx

Overview:
Parametrised multi-channel feedback delay (echo) effect. It sits between the i2s_cdc receive path (o_audio_*/o_audio_valid) and its transmit inputs, in the i_clk domain, and processes one frame per 96 kHz valid tick. It generalises the mono delay with a per-build channel count, data width and depth. It adds a ping-pong (cross-channel feedback) mode, a bypass mode, a power-up memory clear and overrun detection.

Parameters:
DATA_BIT, 16, sample width (two's complement)
ADDR_WIDTH, 14, log2 of per-channel delay depth in samples
CHANNELS, 2, number of audio channels (1..8)

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_audio  in  CHANNELS*DATA_BIT  input frame; channel c at bits [c*DATA_BIT +: DATA_BIT]
i_audio_valid  in  1  one-cycle frame strobe
i_delay  in  ADDR_WIDTH  delay in samples; 0 means 2^ADDR_WIDTH
i_feedback  in  16  signed Q2.14 feedback gain (0x4000 = 1.0)
i_wet  in  16  signed Q2.14 delayed-path gain
i_dry  in  16  signed Q2.14 direct-path gain
i_mode  in  2  00 normal, 01 ping-pong, 10 bypass, 11 treated as normal
o_audio  out  CHANNELS*DATA_BIT  processed frame, same packing as i_audio
o_audio_valid  out  1  one-cycle strobe, o_audio is valid on it and held until the next one
o_ready  out  1  high when idle and able to accept a frame
o_overrun  out  1  one-cycle pulse when a strobe is dropped

Behaviour:
- Reset: o_audio=0, o_audio_valid=0, o_ready=0, o_overrun=0, write pointer=0, FSM=CLEAR.
- CLEAR: write zero to every RAM word, one word per cycle, CHANNELS*2^ADDR_WIDTH cycles. o_ready rises the cycle after the last write. Strobes during CLEAR are dropped with an o_overrun pulse.
- IDLE: on i_audio_valid, latch i_audio, gains, i_mode and i_delay; drop o_ready; go to READ.
- READ (CHANNELS cycles): issue read of address {c, wr_ptr - delay} mod 2^ADDR_WIDTH for c=0..C-1. RAM latency is 1 cycle. Capture d_c into a register bank.
- WAIT (1 cycle): capture the last read.
- WRITE (CHANNELS cycles), channel c per cycle:
  - fb source f = d_c (normal/bypass), or d_((c+1) mod C) (ping-pong; for C=1 this is d_0).
  - mem[{c, wr_ptr}] = sat(x_c + (f*fb)>>>14).
  - y_c = sat((x_c*dry + d_c*wet)>>>14); in bypass, y_c = x_c.
  - Products are 16 x DATA_BIT signed, full width; the sum is arithmetic-shifted by 14 and then saturated to DATA_BIT.
- After the last WRITE: wr_ptr increments and wraps mod 2^ADDR_WIDTH; o_audio updates; o_audio_valid pulses; o_ready returns high.
- Latency: with the strobe sampled at edge 0, o_audio_valid is high in the cycle after edge 2*CHANNELS+2. For C=2 that is 6 cycles.
- A strobe while o_ready=0 is ignored, pulses o_overrun for 1 cycle, and leaves state untouched.
- Gain, delay and mode changes take effect only at the next accepted strobe.
- Reset asserted mid-operation: immediate return to reset values and CLEAR is restarted. A partial frame is never output.
- Bypass still writes memory, so switching out of bypass resumes with valid history.

Decomposition:
- Package multitap_delay_pkg:
  - mode enum (MODE_NORMAL, MODE_PINGPONG, MODE_BYPASS)
  - FSM state enum
  - Q_FRAC=14
  - function sat_data (saturate to DATA_BIT)
- Sub-module delay_ram: single-port synchronous RAM, depth CHANNELS*2^ADDR_WIDTH, read latency 1, no reset, so it infers BRAM.

Test Plan:
(bench: ADDR_WIDTH=4, CHANNELS=2, strobe every 20 cycles)
1. Release reset -> o_ready stays 0 for 32 cycles, then 1; a strobe at cycle 10 gives o_overrun pulse and no o_audio_valid.
2. Bypass, L=1234, R=-5 -> o_audio_valid 6 cycles after the strobe; L=1234, R=-5.
3. Normal, delay=3, fb=0, wet=0x4000, dry=0, L impulse 1000 at frame 0 -> L=1000 at frame 3 only, R=0 always.
4. Same as 3 with fb=0x2000 -> L echoes 1000, 500, 250, 125 at frames 3, 6, 9, 12.
5. Ping-pong, delay=3, fb=0x4000, wet=0x4000, dry=0, L impulse 1000 -> L=1000 at frame 3, R=1000 at frame 6, L=1000 at frame 9.
6. dry=wet=0x4000, input 32767 with delayed 32767 -> output 32767 (saturated); input -32768 case -> -32768. Two strobes 1 cycle apart -> second dropped, one o_overrun pulse.
